// File: rtl/spi_slave.sv
// SPI mode-0 slave (8-bit frames, MSB first) behind a zero-wait-state register bus.
// Define SPI_SLAVE_IRQ_EN to enable the CTRL register and the registered receive interrupt.
module spi_slave #(
  parameter int SYNC_STAGES = 2
) (
  input  logic        HCLK,
  input  logic        RSTn,
  input  logic        spi_sel,
  input  logic        spi_req,
  input  logic        spi_write,
  input  logic [1:0]  spi_addr,
  input  logic [7:0]  spi_wdata,
  output logic        spi_gnt,
  output logic        spi_rvalid,
  output logic [31:0] spi_rdata,
  input  logic        SCK,
  input  logic        SSn,
  input  logic        MOSI,
  output logic        MISO,
  output logic        irq
);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_LOAD  = 2'd1,
    ST_SHIFT = 2'd2
  } state_e;

  logic [SYNC_STAGES-1:0] sck_sync_q, sck_sync_d;
  logic [SYNC_STAGES-1:0] ss_sync_q, ss_sync_d;
  logic [SYNC_STAGES-1:0] mosi_sync_q, mosi_sync_d;
  logic [SYNC_STAGES-1:0] primed_q, primed_d;
  logic                   sck_prev_q, ss_prev_q;
  logic                   ss_armed_q, ss_armed_d;
  logic                   sck_s, ss_s, mosi_s;
  logic                   sck_rise, sck_fall, ss_fall, busy;

  state_e     state_q, state_d;
  logic [7:0] tx_shift_q, tx_shift_d;
  logic [7:0] tx_hold_q, tx_hold_d;
  logic [7:0] rx_shift_q, rx_shift_d;
  logic [7:0] rx_byte_q, rx_byte_d;
  logic [2:0] bit_cnt_q, bit_cnt_d;
  logic       rx_full_q, rx_full_d;
  logic       tx_empty_q, tx_empty_d;
  logic       overrun_q, overrun_d;
  logic       rvalid_q, rvalid_d;
  logic [31:0] rdata_q, rdata_d;

  logic gnt, wr_data, rd_data, wr_status, tx_load, byte_done, ctrl_en;

  // Synchronizer shift chains; primed_q marks when the last stage reflects the real pins.
  always_comb begin
    sck_sync_d  = sck_sync_q;
    ss_sync_d   = ss_sync_q;
    mosi_sync_d = mosi_sync_q;
    primed_d    = primed_q;
    for (int i = 1; i < SYNC_STAGES; i++) begin
      sck_sync_d[i]  = sck_sync_q[i-1];
      ss_sync_d[i]   = ss_sync_q[i-1];
      mosi_sync_d[i] = mosi_sync_q[i-1];
      primed_d[i]    = primed_q[i-1];
    end
    sck_sync_d[0]  = SCK;
    ss_sync_d[0]   = SSn;
    mosi_sync_d[0] = MOSI;
    primed_d[0]    = 1'b1;
  end

  assign sck_s    = sck_sync_q[SYNC_STAGES-1];
  assign ss_s     = ss_sync_q[SYNC_STAGES-1];
  assign mosi_s   = mosi_sync_q[SYNC_STAGES-1];
  assign sck_rise = sck_s & ~sck_prev_q;
  assign sck_fall = ~sck_s & sck_prev_q;
  assign ss_fall  = ~ss_s & ss_prev_q;
  assign busy     = ~ss_s;

  // A frame may only start after SSn has been seen high at the pin since reset.
  assign ss_armed_d = ss_armed_q | (primed_q[SYNC_STAGES-1] & ss_s);

  assign gnt       = spi_req & spi_sel;
  assign spi_gnt   = gnt;
  assign wr_data   = gnt & spi_write & (spi_addr == 2'd0);
  assign rd_data   = gnt & ~spi_write & (spi_addr == 2'd0);
  assign wr_status = gnt & spi_write & (spi_addr == 2'd1);

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:  if (ss_fall && ss_armed_q) state_d = ST_LOAD;
      ST_LOAD:  state_d = ss_s ? ST_IDLE : ST_SHIFT;
      ST_SHIFT: if (ss_s) state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
  end

  assign tx_load   = (state_q == ST_LOAD) |
                     ((state_q == ST_SHIFT) & ~ss_s & sck_fall & (bit_cnt_q == 3'd0));
  assign byte_done = (state_q == ST_SHIFT) & ~ss_s & sck_rise & (bit_cnt_q == 3'd7);

  always_comb begin
    tx_shift_d = tx_shift_q;
    tx_hold_d  = tx_hold_q;
    tx_empty_d = tx_empty_q;
    rx_shift_d = rx_shift_q;
    rx_byte_d  = rx_byte_q;
    bit_cnt_d  = bit_cnt_q;
    rx_full_d  = rx_full_q;
    overrun_d  = overrun_q;

    if (tx_load) begin
      tx_shift_d = tx_empty_q ? 8'h00 : tx_hold_q;
      tx_empty_d = 1'b1;
    end else if ((state_q == ST_SHIFT) && !ss_s && sck_fall) begin
      tx_shift_d = {tx_shift_q[6:0], 1'b0};
    end
    // A bus write in the same cycle as a load lands after it.
    if (wr_data) begin
      tx_hold_d  = spi_wdata;
      tx_empty_d = 1'b0;
    end

    if (state_q == ST_LOAD) begin
      bit_cnt_d = 3'd0;
    end else if (state_q == ST_SHIFT) begin
      if (ss_s) begin
        bit_cnt_d  = 3'd0;
        rx_shift_d = 8'h00;
      end else if (sck_rise) begin
        rx_shift_d = {rx_shift_q[6:0], mosi_s};
        bit_cnt_d  = bit_cnt_q + 3'd1;
      end
    end

    if (rd_data) rx_full_d = 1'b0;
    if (wr_status && spi_wdata[2]) overrun_d = 1'b0;
    if (byte_done) begin
      rx_byte_d = {rx_shift_q[6:0], mosi_s};
      rx_full_d = 1'b1;
      if (rx_full_q && !rd_data) overrun_d = 1'b1;
    end
  end

  always_comb begin
    rvalid_d = gnt;
    rdata_d  = 32'h0;
    if (gnt && !spi_write) begin
      case (spi_addr)
        2'd0:    rdata_d = {24'h0, rx_byte_q};
        2'd1:    rdata_d = {28'h0, busy, overrun_q, tx_empty_q, rx_full_q};
        2'd2:    rdata_d = {31'h0, ctrl_en};
        default: rdata_d = 32'h0;
      endcase
    end
  end

  always_ff @(posedge HCLK or negedge RSTn) begin
    if (!RSTn) begin
      sck_sync_q  <= '0;
      ss_sync_q   <= '1;
      mosi_sync_q <= '0;
      primed_q    <= '0;
      sck_prev_q  <= 1'b0;
      ss_prev_q   <= 1'b1;
      ss_armed_q  <= 1'b0;
      state_q     <= ST_IDLE;
      tx_shift_q  <= 8'h00;
      tx_hold_q   <= 8'h00;
      rx_shift_q  <= 8'h00;
      rx_byte_q   <= 8'h00;
      bit_cnt_q   <= 3'd0;
      rx_full_q   <= 1'b0;
      tx_empty_q  <= 1'b1;
      overrun_q   <= 1'b0;
      rvalid_q    <= 1'b0;
      rdata_q     <= 32'h0;
    end else begin
      sck_sync_q  <= sck_sync_d;
      ss_sync_q   <= ss_sync_d;
      mosi_sync_q <= mosi_sync_d;
      primed_q    <= primed_d;
      sck_prev_q  <= sck_s;
      ss_prev_q   <= ss_s;
      ss_armed_q  <= ss_armed_d;
      state_q     <= state_d;
      tx_shift_q  <= tx_shift_d;
      tx_hold_q   <= tx_hold_d;
      rx_shift_q  <= rx_shift_d;
      rx_byte_q   <= rx_byte_d;
      bit_cnt_q   <= bit_cnt_d;
      rx_full_q   <= rx_full_d;
      tx_empty_q  <= tx_empty_d;
      overrun_q   <= overrun_d;
      rvalid_q    <= rvalid_d;
      rdata_q     <= rdata_d;
    end
  end

  assign spi_rvalid = rvalid_q;
  assign spi_rdata  = rdata_q;
  assign MISO       = busy & tx_shift_q[7];

`ifdef SPI_SLAVE_IRQ_EN
  logic ctrl_en_q, ctrl_en_d, irq_q, irq_d, wr_ctrl;

  assign wr_ctrl = gnt & spi_write & (spi_addr == 2'd2);

  always_comb begin
    ctrl_en_d = ctrl_en_q;
    if (wr_ctrl) ctrl_en_d = spi_wdata[0];
    irq_d = rx_full_q & ctrl_en_q;
  end

  always_ff @(posedge HCLK or negedge RSTn) begin
    if (!RSTn) begin
      ctrl_en_q <= 1'b0;
      irq_q     <= 1'b0;
    end else begin
      ctrl_en_q <= ctrl_en_d;
      irq_q     <= irq_d;
    end
  end

  assign ctrl_en = ctrl_en_q;
  assign irq     = irq_q;
`else
  assign ctrl_en = 1'b0;
  assign irq     = 1'b0;
`endif

endmodule

// File: tb/tb_spi_slave.sv
// Self-checking bench for spi_slave: bus reads and MISO bits are scoreboarded against
// expectations queued when the stimulus is issued.
module tb_spi_slave;
  localparam int SYNC_STAGES = 2;
`ifdef SPI_SLAVE_IRQ_EN
  localparam logic IRQ_EN = 1'b1;
`else
  localparam logic IRQ_EN = 1'b0;
`endif

  logic        HCLK = 1'b0;
  logic        RSTn;
  logic        spi_sel, spi_req, spi_write;
  logic [1:0]  spi_addr;
  logic [7:0]  spi_wdata;
  logic        spi_gnt, spi_rvalid;
  logic [31:0] spi_rdata;
  logic        SCK, SSn, MOSI, MISO, irq;

  int n_checks = 0;
  int n_errors = 0;
  logic [31:0] exp_q[$];
  logic [0:0]  miso_q[$];

  spi_slave #(.SYNC_STAGES(SYNC_STAGES)) dut (
    .HCLK(HCLK), .RSTn(RSTn),
    .spi_sel(spi_sel), .spi_req(spi_req), .spi_write(spi_write),
    .spi_addr(spi_addr), .spi_wdata(spi_wdata),
    .spi_gnt(spi_gnt), .spi_rvalid(spi_rvalid), .spi_rdata(spi_rdata),
    .SCK(SCK), .SSn(SSn), .MOSI(MOSI), .MISO(MISO), .irq(irq)
  );

  // Clock and watchdog
  always #5 HCLK = ~HCLK;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation exceeded time budget");
    $fatal(1, "watchdog expired");
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Driver tasks; all are entered on a falling HCLK edge.
  task automatic bus_access(input logic wr, input logic [1:0] addr, input logic [7:0] wdata,
                            input logic [31:0] mask, input string tag);
    logic [31:0] exp;
    spi_sel = 1'b1; spi_req = 1'b1; spi_write = wr; spi_addr = addr; spi_wdata = wdata;
    #1;
    check_eq({tag, "_gnt"}, {31'h0, spi_gnt}, 32'h1);
    check_eq({tag, "_rvalid_before"}, {31'h0, spi_rvalid}, 32'h0);
    @(negedge HCLK);
    spi_sel = 1'b0; spi_req = 1'b0; spi_write = 1'b0;
    check_eq({tag, "_rvalid"}, {31'h0, spi_rvalid}, 32'h1);
    if (wr) begin
      check_eq({tag, "_wr_rdata"}, spi_rdata, 32'h0);
    end else begin
      check_eq({tag, "_exp_q_size"}, exp_q.size(), 32'h1);
      if (exp_q.size() > 0) begin
        exp = exp_q.pop_front();
        check_eq(tag, spi_rdata & mask, exp & mask);
      end
    end
    @(negedge HCLK);
    check_eq({tag, "_rvalid_after"}, {31'h0, spi_rvalid}, 32'h0);
    check_eq({tag, "_rdata_after"}, spi_rdata, 32'h0);
  endtask

  task automatic bus_rd(input string tag, input logic [1:0] addr, input logic [31:0] exp,
                        input logic [31:0] mask);
    exp_q.push_back(exp);
    bus_access(1'b0, addr, 8'h00, mask, tag);
  endtask

  task automatic bus_wr(input logic [1:0] addr, input logic [7:0] data);
    bus_access(1'b1, addr, data, 32'hffff_ffff, "wr");
  endtask

  task automatic ss_start();
    SSn = 1'b0;
    repeat (8) @(negedge HCLK);
  endtask

  task automatic ss_end();
    repeat (4) @(negedge HCLK);
    SSn = 1'b1;
    repeat (8) @(negedge HCLK);
  endtask

  // Shifts nbits of mo MSB first; mi holds the MISO bits expected at each rising SCK edge.
  task automatic spi_xfer(input logic [7:0] mo, input logic [7:0] mi, input int nbits,
                          input logic rd_last, input logic [7:0] rd_exp);
    logic [0:0] e;
    for (int i = 7; i >= 8 - nbits; i--) miso_q.push_back(mi[i]);
    for (int i = 7; i >= 8 - nbits; i--) begin
      MOSI = mo[i];
      repeat (8) @(negedge HCLK);
      check_eq("miso_q_size", miso_q.size(), 32'(i - (8 - nbits) + 1));
      if (miso_q.size() > 0) begin
        e = miso_q.pop_front();
        check_eq($sformatf("miso_bit%0d", i), {31'h0, MISO}, {31'h0, e});
      end
      SCK = 1'b1;
      if (rd_last && i == 0) begin
        // Lands the bus read in the cycle the 8th rising edge is acted on.
        repeat (SYNC_STAGES) @(negedge HCLK);
        bus_rd("rd_coincide", 2'd0, {24'h0, rd_exp}, 32'hffff_ffff);
        repeat (4) @(negedge HCLK);
      end else begin
        repeat (8) @(negedge HCLK);
      end
      SCK = 1'b0;
    end
  endtask

  initial begin
    RSTn = 1'b0; spi_sel = 1'b0; spi_req = 1'b0; spi_write = 1'b0;
    spi_addr = 2'd0; spi_wdata = 8'h00; SCK = 1'b0; SSn = 1'b1; MOSI = 1'b0;
    repeat (3) @(negedge HCLK);
    check_eq("rst_rvalid", {31'h0, spi_rvalid}, 32'h0);
    check_eq("rst_rdata", spi_rdata, 32'h0);
    check_eq("rst_miso", {31'h0, MISO}, 32'h0);
    check_eq("rst_irq", {31'h0, irq}, 32'h0);
    RSTn = 1'b1;
    repeat (4) @(negedge HCLK);
    bus_rd("rst_status", 2'd1, 32'h2, 32'hffff_ffff);
    bus_rd("rst_data", 2'd0, 32'h0, 32'hffff_ffff);
    bus_rd("rst_ctrl", 2'd2, 32'h0, 32'hffff_ffff);
    bus_wr(2'd3, 8'hff);
    bus_rd("idx3", 2'd3, 32'h0, 32'hffff_ffff);

    // No grant without both select and request
    spi_sel = 1'b1; spi_req = 1'b0; #1;
    check_eq("gnt_no_req", {31'h0, spi_gnt}, 32'h0);
    @(negedge HCLK);
    check_eq("rvalid_no_req", {31'h0, spi_rvalid}, 32'h0);
    spi_sel = 1'b0; spi_req = 1'b1; #1;
    check_eq("gnt_no_sel", {31'h0, spi_gnt}, 32'h0);
    @(negedge HCLK);
    check_eq("rvalid_no_sel", {31'h0, spi_rvalid}, 32'h0);
    spi_req = 1'b0;

    // Basic full-duplex byte
    bus_wr(2'd0, 8'hA5);
    bus_rd("status_tx_full", 2'd1, 32'h0, 32'hffff_ffff);
    ss_start();
    spi_xfer(8'h3C, 8'hA5, 8, 1'b0, 8'h00);
    bus_rd("status_in_frame", 2'd1, 32'h9, 32'h9);
    ss_end();
    bus_rd("data_3c", 2'd0, 32'h3C, 32'hffff_ffff);
    bus_rd("status_after_3c", 2'd1, 32'h2, 32'hffff_ffff);

    // Overrun on two unread frames, MISO idle-zero with nothing queued
    ss_start(); spi_xfer(8'h11, 8'h00, 8, 1'b0, 8'h00); ss_end();
    ss_start(); spi_xfer(8'h22, 8'h00, 8, 1'b0, 8'h00); ss_end();
    bus_rd("status_overrun", 2'd1, 32'h7, 32'hffff_ffff);
    bus_rd("data_22", 2'd0, 32'h22, 32'hffff_ffff);
    bus_rd("status_ovr_kept", 2'd1, 32'h6, 32'hffff_ffff);
    bus_wr(2'd1, 8'h04);
    bus_rd("status_ovr_clr", 2'd1, 32'h2, 32'hffff_ffff);

    // Back-to-back bytes with refill after the first load
    bus_wr(2'd0, 8'hC3);
    ss_start();
    bus_wr(2'd0, 8'h5A);
    spi_xfer(8'h81, 8'hC3, 8, 1'b0, 8'h00);
    spi_xfer(8'h42, 8'h5A, 8, 1'b0, 8'h00);
    spi_xfer(8'h99, 8'h00, 8, 1'b0, 8'h00);
    ss_end();
    bus_rd("status_b2b", 2'd1, 32'h7, 32'hffff_ffff);
    bus_rd("data_99", 2'd0, 32'h99, 32'hffff_ffff);
    bus_wr(2'd1, 8'h04);

    // Aborted partial byte, then a clean one
    ss_start(); spi_xfer(8'hA8, 8'h00, 5, 1'b0, 8'h00); ss_end();
    bus_rd("status_partial", 2'd1, 32'h2, 32'hffff_ffff);
    ss_start(); spi_xfer(8'h7E, 8'h00, 8, 1'b0, 8'h00); ss_end();
    bus_rd("status_7e", 2'd1, 32'h3, 32'hffff_ffff);
    bus_rd("data_7e", 2'd0, 32'h7E, 32'hffff_ffff);

    // DATA read coinciding with byte completion
    ss_start();
    spi_xfer(8'h55, 8'h00, 8, 1'b0, 8'h00);
    spi_xfer(8'h66, 8'h00, 8, 1'b1, 8'h55);
    ss_end();
    bus_rd("status_coincide", 2'd1, 32'h3, 32'hffff_ffff);
    bus_rd("data_66", 2'd0, 32'h66, 32'hffff_ffff);
    bus_rd("status_after_66", 2'd1, 32'h2, 32'hffff_ffff);

    // CTRL and interrupt
    bus_wr(2'd2, 8'h01);
    bus_rd("ctrl_rb", 2'd2, {31'h0, IRQ_EN}, 32'hffff_ffff);
    check_eq("irq_idle", {31'h0, irq}, 32'h0);
    ss_start(); spi_xfer(8'h3A, 8'h00, 8, 1'b0, 8'h00); ss_end();
    check_eq("irq_rx", {31'h0, irq}, {31'h0, IRQ_EN});
    bus_rd("data_3a", 2'd0, 32'h3A, 32'hffff_ffff);
    check_eq("irq_cleared", {31'h0, irq}, 32'h0);

    // Reset mid-frame; SSn held low afterwards must not start a frame
    bus_wr(2'd0, 8'hE7);
    ss_start();
    spi_xfer(8'h12, 8'hE7, 3, 1'b0, 8'h00);
    RSTn = 1'b0;
    #1;
    check_eq("midrst_miso", {31'h0, MISO}, 32'h0);
    check_eq("midrst_rvalid", {31'h0, spi_rvalid}, 32'h0);
    check_eq("midrst_rdata", spi_rdata, 32'h0);
    check_eq("midrst_irq", {31'h0, irq}, 32'h0);
    repeat (3) @(negedge HCLK);
    RSTn = 1'b1;
    repeat (8) @(negedge HCLK);
    bus_rd("status_post_rst", 2'd1, 32'hA, 32'hffff_ffff);
    spi_xfer(8'hFF, 8'h00, 8, 1'b0, 8'h00);
    bus_rd("status_stale_ss", 2'd1, 32'hA, 32'hffff_ffff);
    ss_end();
    bus_rd("status_rst_idle", 2'd1, 32'h2, 32'hffff_ffff);
    bus_rd("ctrl_post_rst", 2'd2, 32'h0, 32'hffff_ffff);
    bus_rd("data_post_rst", 2'd0, 32'h0, 32'hffff_ffff);

    // Overwrite of an unsent holding byte
    bus_wr(2'd0, 8'h11);
    bus_wr(2'd0, 8'h3C);
    ss_start(); spi_xfer(8'hC5, 8'h3C, 8, 1'b0, 8'h00); ss_end();
    bus_rd("data_c5", 2'd0, 32'hC5, 32'hffff_ffff);
    bus_rd("status_final", 2'd1, 32'h2, 32'hffff_ffff);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
